// File: rtl/vedic_seq_mul.sv
// Sequential WIDTH x WIDTH unsigned multiplier: one (WIDTH/2)x(WIDTH/2) Urdhva
// sub-multiplier reused over four cycles, partial products summed by a ha/fa ripple adder.

module vedic_ha (
   input  logic x,
   input  logic y,
   output logic s,
   output logic c
);
   assign s = x ^ y;
   assign c = x & y;
endmodule

module vedic_fa (
   input  logic x,
   input  logic y,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = x ^ y ^ ci;
   assign co = (x & y) | (ci & (x ^ y));
endmodule

module vedic_seq_mul #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] product,
   output logic               busy
);
   localparam int H  = WIDTH / 2;
   localparam int PW = 2 * WIDTH;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t            state, state_nxt;
   logic [1:0]        step;
   logic [WIDTH-1:0]  a_q, b_q;
   logic [H-1:0]      op_a, op_b;
   logic [WIDTH-1:0]  pp;
   logic [PW-1:0]     acc, pp_ext, sum;
   logic [PW-2:0]     carry;
   logic              accept;

   // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
   // valid never waits on ready, and a held valid keeps its payload stable until the transfer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            accept   = in_valid;
            if (in_valid) state_nxt = CALC;
         end
         CALC: begin
            if (step == 2'd3) state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // step[0] picks the half of a, step[1] the half of b: AL*BL, AH*BL, AL*BH, AH*BH.
   assign op_a = step[0] ? a_q[WIDTH-1:H] : a_q[H-1:0];
   assign op_b = step[1] ? b_q[WIDTH-1:H] : b_q[H-1:0];
   assign pp   = {{H{1'b0}}, op_a} * {{H{1'b0}}, op_b};

   always_comb begin
      pp_ext = '0;
      case (step)
         2'd0:    pp_ext = {{WIDTH{1'b0}}, pp};
         2'd1,
         2'd2:    pp_ext = {{H{1'b0}}, pp, {H{1'b0}}};
         default: pp_ext = {pp, {WIDTH{1'b0}}};
      endcase
   end

   // Ripple accumulator; the top bit needs no carry-out since acc never exceeds the product.
   vedic_ha u_ha0 (.x(acc[0]), .y(pp_ext[0]), .s(sum[0]), .c(carry[0]));

   for (genvar i = 1; i < PW - 1; i++) begin : g_fa
      vedic_fa u_fa (.x(acc[i]), .y(pp_ext[i]), .ci(carry[i-1]), .s(sum[i]), .co(carry[i]));
   end

   assign sum[PW-1] = acc[PW-1] ^ pp_ext[PW-1] ^ carry[PW-2];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         acc     <= '0;
         step    <= '0;
         product <= '0;
      end else if (accept) begin
         a_q  <= a;
         b_q  <= b;
         acc  <= '0;
         step <= '0;
      end else if (state == CALC) begin
         acc  <= sum;
         step <= step + 2'd1;
         if (step == 2'd3) product <= sum;
      end
   end
endmodule
